// File: rtl/demux_seq_pkg.sv
// rtl/demux_seq_pkg.sv - shared types and constants for the demux14 select sequencer
package demux_seq_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

  localparam logic [1:0] CH_X = 2'd0;
  localparam logic [1:0] CH_Y = 2'd1;
  localparam logic [1:0] CH_Z = 2'd2;
  localparam logic [1:0] CH_W = 2'd3;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_ADDR = 1'b1;

  // First enabled channel at or after ptr, searching cyclically; returns ptr if none.
  function automatic logic [1:0] next_enabled(input logic [1:0] ptr, input logic [3:0] mask);
    logic [1:0] c;
    next_enabled = ptr;
    for (int k = 3; k >= 0; k--) begin
      c = ptr + 2'(k);
      if (mask[c]) next_enabled = c;
    end
  endfunction

endpackage

// File: rtl/demux14.sv
// rtl/demux14.sv - 1-to-4 demux: routes i to x/y/z/w selected by {s1,s2} while e is high
module demux14 (
  input  logic s1,
  input  logic s2,
  input  logic i,
  input  logic e,
  output logic x,
  output logic y,
  output logic z,
  output logic w
);

  assign x = e & i & ~s1 & ~s2;
  assign y = e & i & ~s1 &  s2;
  assign z = e & i &  s1 & ~s2;
  assign w = e & i &  s1 &  s2;

endmodule

// File: rtl/demux_seq_timer.sv
// rtl/demux_seq_timer.sv - loadable down-counter with zero flag for the SETUP/STROBE phases
module demux_seq_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/demux_sel_sequencer.sv
// rtl/demux_sel_sequencer.sv - glitch-free s1/s2/i/e sequencer for demux14; optional DEMUX_SEQ_MASK_EN
module demux_sel_sequencer
  import demux_seq_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 2,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_data,
  input  logic       mode,
  input  logic [1:0] in_addr,
`ifdef DEMUX_SEQ_MASK_EN
  input  logic [3:0] ch_mask,
  output logic       drop,
`endif
  output logic       s1,
  output logic       s2,
  output logic       i,
  output logic       e,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SETUP  = SETUP;
  localparam logic [1:0] S_STROBE = STROBE;
  localparam logic [1:0] S_GAP    = GAP;

  logic [1:0]       state;
  logic [1:0]       rr_ptr;
  logic             mode_r;
  logic [1:0]       ch_sel;
  logic             accept;
  logic             addr_masked;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;

`ifdef DEMUX_SEQ_MASK_EN
  assign ch_sel      = (mode == MODE_ADDR) ? in_addr : next_enabled(rr_ptr, ch_mask);
  assign addr_masked = (mode == MODE_ADDR) && !ch_mask[in_addr];
  // An all-masked round-robin request has nowhere to go, so it is held off.
  assign in_ready    = (state == S_IDLE) && ((mode == MODE_ADDR) || (ch_mask != 4'b0000));
`else
  assign ch_sel      = (mode == MODE_ADDR) ? in_addr : rr_ptr;
  assign addr_masked = 1'b0;
  assign in_ready    = (state == S_IDLE);
`endif

  assign accept  = in_valid && in_ready;
  assign busy    = (state != S_IDLE);
  assign tmr_dec = (state == S_SETUP) || (state == S_STROBE);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if ((state == S_IDLE) && accept && !addr_masked) begin
      tmr_load = 1'b1;
      tmr_val  = CNT_W'(SETUP_CYC - 1);
    end else if ((state == S_SETUP) && tmr_zero) begin
      tmr_load = 1'b1;
      tmr_val  = CNT_W'(HOLD_CYC - 1);
    end
  end

  demux_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // e and done are registered so demux14 never sees a decode glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      rr_ptr <= 2'd0;
      mode_r <= MODE_RR;
      s1     <= 1'b0;
      s2     <= 1'b0;
      i      <= 1'b0;
      e      <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && !addr_masked) begin
            i      <= in_data;
            s1     <= ch_sel[1];
            s2     <= ch_sel[0];
            mode_r <= mode;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tmr_zero) begin
            e     <= 1'b1;
            state <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (tmr_zero) begin
            e     <= 1'b0;
            done  <= 1'b1;
            state <= S_GAP;
          end
        end
        default: begin
          // Advancing from the used channel also covers skipping masked channels.
          if (mode_r == MODE_RR) rr_ptr <= {s1, s2} + 2'd1;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DEMUX_SEQ_MASK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop <= 1'b0;
    end else begin
      drop <= accept && addr_masked;
    end
  end
`endif

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// tb/tb_demux_sel_sequencer.sv - directed self-checking bench for demux_sel_sequencer driving demux14
module tb_demux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_data;
  logic       mode;
  logic [1:0] in_addr;
  logic       s1, s2, i, e, busy, done;
  logic       x, y, z, w;
`ifdef DEMUX_SEQ_MASK_EN
  logic [3:0] ch_mask = 4'hF;
  logic       drop;
`endif

  int errors = 0;
  int checks = 0;

  logic [4:0] obs_e, obs_done, obs_rdy;
  int         cnt_ch [4];

  always #5 clk = ~clk;

  demux_sel_sequencer #(.SETUP_CYC(1), .HOLD_CYC(2), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .mode     (mode),
    .in_addr  (in_addr),
`ifdef DEMUX_SEQ_MASK_EN
    .ch_mask  (ch_mask),
    .drop     (drop),
`endif
    .s1       (s1),
    .s2       (s2),
    .i        (i),
    .e        (e),
    .busy     (busy),
    .done     (done)
  );

  demux14 u_demux (.s1(s1), .s2(s2), .i(i), .e(e), .x(x), .y(y), .z(z), .w(w));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one item at the current point, then samples five negedges after the accepting edge.
  task automatic send(input logic m, input logic [1:0] a, input logic d);
    in_valid = 1'b1;
    mode     = m;
    in_addr  = a;
    in_data  = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
    obs_e = '0; obs_done = '0; obs_rdy = '0;
    for (int c = 0; c < 4; c++) cnt_ch[c] = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      obs_e[k]    = e;
      obs_done[k] = done;
      obs_rdy[k]  = in_ready;
      if (x) cnt_ch[0]++;
      if (y) cnt_ch[1]++;
      if (z) cnt_ch[2]++;
      if (w) cnt_ch[3]++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic saw_e;
    rst_n = 1'b0; in_valid = 1'b1; mode = 1'b0; in_addr = 2'd0; in_data = 1'b1;
    saw_e = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (e) saw_e = 1'b1;
    end
    checks++;
    if ({s1, s2, i, e, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000", {s1, s2, i, e, busy, done});
    end
    checks++;
    if (saw_e !== 1'b0) begin errors++; $display("FAIL reset_no_strobe: e seen high during reset"); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    send(1'b0, 2'd0, 1'b1);
    checks++;
    if (obs_rdy !== 5'b10000) begin errors++; $display("FAIL first_ready_seq: got %b want 10000", obs_rdy); end
    checks++;
    if (obs_e !== 5'b00110) begin errors++; $display("FAIL first_e_seq: got %b want 00110", obs_e); end
    checks++;
    if (obs_done !== 5'b01000) begin errors++; $display("FAIL first_done_seq: got %b want 01000", obs_done); end
    checks++;
    if (cnt_ch[0] !== 2) begin errors++; $display("FAIL first_x: got %0d cycles want 2", cnt_ch[0]); end
  endtask

  task automatic test_round_robin();
    int others;
    do_reset();
    for (int n = 0; n < 5; n++) begin
      send(1'b0, 2'd3, 1'b1);
      others = cnt_ch[0] + cnt_ch[1] + cnt_ch[2] + cnt_ch[3] - cnt_ch[n % 4];
      checks++;
      if (cnt_ch[n % 4] !== 2) begin
        errors++;
        $display("FAIL rr_item%0d_channel: ch%0d high %0d cycles want 2", n, n % 4, cnt_ch[n % 4]);
      end
      checks++;
      if (others !== 0) begin
        errors++;
        $display("FAIL rr_item%0d_others: got %0d cycles want 0", n, others);
      end
    end
  endtask

  task automatic test_addressed();
    send(1'b1, 2'd2, 1'b1);
    checks++;
    if (cnt_ch[2] !== 2 || cnt_ch[0] + cnt_ch[1] + cnt_ch[3] !== 0) begin
      errors++;
      $display("FAIL addr_z: x=%0d y=%0d z=%0d w=%0d want 0 0 2 0", cnt_ch[0], cnt_ch[1], cnt_ch[2], cnt_ch[3]);
    end
    send(1'b1, 2'd1, 1'b0);
    checks++;
    if (obs_e !== 5'b00110) begin errors++; $display("FAIL addr_zero_e: got %b want 00110", obs_e); end
    checks++;
    if (cnt_ch[0] + cnt_ch[1] + cnt_ch[2] + cnt_ch[3] !== 0) begin
      errors++; $display("FAIL addr_zero_data: channel outputs high with i=0");
    end
    checks++;
    if ({s1, s2, i} !== 3'b010) begin errors++; $display("FAIL addr_held_sel: got %b want 010", {s1, s2, i}); end
    send(1'b0, 2'd0, 1'b1);
    checks++;
    if (cnt_ch[1] !== 2 || cnt_ch[0] + cnt_ch[2] + cnt_ch[3] !== 0) begin
      errors++;
      $display("FAIL addr_rr_resume: x=%0d y=%0d z=%0d w=%0d want 0 2 0 0", cnt_ch[0], cnt_ch[1], cnt_ch[2], cnt_ch[3]);
    end
  endtask

  task automatic test_stability();
    int wc;
    wc = 0;
    in_valid = 1'b1; mode = 1'b1; in_addr = 2'd3; in_data = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (w) wc++;
      checks++;
      if ({s1, s2, i} !== 3'b111) begin
        errors++; $display("FAIL stable_cycle%0d: sel/data got %b want 111", k + 1, {s1, s2, i});
      end
      in_addr = ~in_addr; in_data = ~in_data; mode = ~mode;
      if (k == 3) in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (wc !== 2) begin errors++; $display("FAIL stable_w: got %0d cycles want 2", wc); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stable_no_reaccept: busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; mode = 1'b0; in_addr = 2'd0; in_data = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL mid_strobe_e: got %b want 1", e); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({e, busy, s1, s2, i} !== 5'b0) begin
      errors++; $display("FAIL mid_reset_async: got %b want 00000", {e, busy, s1, s2, i});
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_idle: ready=%b busy=%b want 1 0", in_ready, busy);
    end
    send(1'b0, 2'd2, 1'b1);
    checks++;
    if (cnt_ch[0] !== 2 || cnt_ch[1] + cnt_ch[2] + cnt_ch[3] !== 0) begin
      errors++;
      $display("FAIL mid_reset_rr_ptr: x=%0d y=%0d z=%0d w=%0d want 2 0 0 0", cnt_ch[0], cnt_ch[1], cnt_ch[2], cnt_ch[3]);
    end
  endtask

`ifdef DEMUX_SEQ_MASK_EN
  task automatic test_mask();
    logic [1:0] exp_ch [3];
    logic saw_e;
    exp_ch[0] = 2'd1; exp_ch[1] = 2'd3; exp_ch[2] = 2'd1;
    do_reset();
    ch_mask = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      send(1'b0, 2'd0, 1'b1);
      checks++;
      if (cnt_ch[exp_ch[n]] !== 2) begin
        errors++; $display("FAIL mask_rr%0d: ch%0d high %0d cycles want 2", n, exp_ch[n], cnt_ch[exp_ch[n]]);
      end
    end
    in_valid = 1'b1; mode = 1'b1; in_addr = 2'd0; in_data = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    checks++;
    if (drop !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL mask_drop: drop=%b busy=%b want 1 0", drop, busy);
    end
    saw_e = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (e) saw_e = 1'b1;
    end
    checks++;
    if (saw_e !== 1'b0) begin errors++; $display("FAIL mask_no_strobe: e seen high"); end
    ch_mask = 4'b0000; mode = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mask_empty_rr_ready: got %b want 0", in_ready); end
    mode = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mask_empty_addr_ready: got %b want 1", in_ready); end
    ch_mask = 4'hF;
  endtask
`endif

  initial begin
    in_valid = 1'b0; in_data = 1'b0; mode = 1'b0; in_addr = 2'd0; rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_addressed();
    test_stability();
    test_reset_mid();
`ifdef DEMUX_SEQ_MASK_EN
    test_mask();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
